// File: rtl/capture_truncate.sv
// Snap-length truncation stage for the capture path: forwards each packet unchanged or cuts it to
// at most snaplen_words beats, fixing up tlast/tstrb/length and counting packets and truncations.
module capture_truncate #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
  input  logic                                axi_aclk,
  input  logic                                axi_areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  output logic                                s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  input  logic [7:0]                          snaplen_words,
  output logic [31:0]                         pkt_count,
  output logic [31:0]                         trunc_count
);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t                             state_q, state_d;
  logic [7:0]                         beat_q, snap_q;
  logic                               m_tvalid_q, m_tlast_q;
  logic [C_M_AXIS_DATA_WIDTH-1:0]     m_tdata_q;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_tstrb_q;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]    m_tuser_q;
  logic [31:0]                        pkt_cnt_q, trunc_cnt_q;

  logic                               s_ready, accept, load, trigger, rewrite, first_beat;
  logic [7:0]                         snap_eff, beat_num;
  logic [13:0]                        trunc_len;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]    tuser_d;

  always_comb begin
    // NOTE: every signal gets a value before any condition, so no path can infer a latch.
    state_d    = state_q;
    tuser_d    = s_axis_tuser;
    // Held low during reset; beats in DROP are swallowed regardless of the output stage.
    s_ready    = !axi_areset && ((state_q == DROP) || !m_tvalid_q || m_axis_tready);
    accept     = s_axis_tvalid && s_ready;
    load       = accept && (state_q != DROP);
    first_beat = (state_q == IDLE);
    snap_eff   = first_beat ? snaplen_words : snap_q;
    beat_num   = first_beat ? 8'd1 : ((beat_q == 8'hFF) ? 8'hFF : beat_q + 8'd1);
    trigger    = load && !s_axis_tlast && (snap_eff != 8'd0) && (beat_num == snap_eff);
    trunc_len  = {1'b0, snap_eff, 5'b00000};
    rewrite    = first_beat && (snap_eff != 8'd0) && ({2'b00, trunc_len} < s_axis_tuser[15:0]);
    if (rewrite) tuser_d[15:0] = {2'b00, trunc_len};

    if (accept) begin
      if (trigger)               state_d = DROP;
      else if (s_axis_tlast)     state_d = IDLE;
      else if (state_q == IDLE)  state_d = PASS;
    end
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      snap_q      <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tdata_q   <= '0;
      m_tstrb_q   <= '0;
      m_tuser_q   <= '0;
      pkt_cnt_q   <= '0;
      trunc_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        beat_q <= beat_num;
        if (first_beat) snap_q <= snaplen_words;
      end

      if (load) begin
        m_tvalid_q <= 1'b1;
        m_tdata_q  <= s_axis_tdata;
        m_tstrb_q  <= trigger ? '1 : s_axis_tstrb;
        m_tlast_q  <= s_axis_tlast || trigger;
        m_tuser_q  <= tuser_d;
      end else if (m_axis_tready) begin
        m_tvalid_q <= 1'b0;
      end

      if (m_tvalid_q && m_axis_tready && m_tlast_q) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (trigger) trunc_cnt_q <= trunc_cnt_q + 32'd1;
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tstrb  = m_tstrb_q;
  assign m_axis_tuser  = m_tuser_q;
  assign pkt_count     = pkt_cnt_q;
  assign trunc_count   = trunc_cnt_q;

endmodule

// File: tb/tb_capture_truncate.sv
// Directed bench for capture_truncate: hand-written expected beats are checked by a negedge
// monitor (including the hold rule while stalled); counters and reset behaviour are checked inline.
module tb_capture_truncate;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int SW = DW / 8;
  localparam logic [UW-17:0] TU_HI = {14{8'hA5}};
  localparam logic [SW-1:0]  FULL  = '1;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic [SW-1:0] s_tstrb;
  logic [UW-1:0] s_tuser;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic [SW-1:0] m_tstrb;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid, m_tlast, m_tready;
  logic [7:0]    snaplen;
  logic [31:0]   pkt_count, trunc_count;

  always #5 clk = ~clk;

  capture_truncate dut (
    .axi_aclk      (clk),
    .axi_areset    (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .snaplen_words (snaplen),
    .pkt_count     (pkt_count),
    .trunc_count   (trunc_count)
  );

  typedef struct packed {
    logic [7:0]    tag;
    logic          last;
    logic [SW-1:0] strb;
    logic [15:0]   len;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   tog_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] tag, input logic last, input logic [SW-1:0] strb,
                      input logic [15:0] len);
    exp_t e;
    e.tag = tag; e.last = last; e.strb = strb; e.len = len;
    exp_q.push_back(e);
  endtask

  // Advance to just after the next rising edge; optionally toggle m_tready every cycle.
  task automatic clk_step();
    @(posedge clk);
    #1;
    if (tog_mode) m_tready = ~m_tready;
  endtask

  task automatic send_beat(input logic [7:0] tag, input logic last, input logic [SW-1:0] strb,
                           input logic [15:0] len, output bit rdy_first);
    bit acc;
    acc       = 1'b0;
    rdy_first = 1'b0;
    s_tdata   = {32{tag}};
    s_tstrb   = strb;
    s_tuser   = {TU_HI, len};
    s_tlast   = last;
    s_tvalid  = 1'b1;
    for (int t = 0; t < 20 && !acc; t++) begin
      #1;
      acc = s_tready;
      if (t == 0) rdy_first = acc;
      clk_step();
    end
    s_tvalid = 1'b0;
    check($sformatf("accept_%0h", tag), 32'(acc), 32'd1);
  endtask

  task automatic send_pkt(input logic [7:0] base, input int n, input logic [15:0] len,
                          input logic [SW-1:0] last_strb);
    bit r;
    for (int i = 0; i < n; i++)
      send_beat(base + 8'(i), (i == n - 1), (i == n - 1) ? last_strb : FULL,
                (i == 0) ? len : 16'd0, r);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && (exp_q.size() != 0 || m_tvalid); t++) clk_step();
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // Output monitor: every master handshake must match the next expected beat, and a stalled
  // beat must be held unchanged into the following cycle.
  initial begin
    bit                 stall_prev;
    logic [DW+SW+UW:0]  held;
    exp_t               e;
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          check_wide("hold_stable", 512'({m_tvalid, m_tdata, m_tstrb, m_tlast, m_tuser}),
                     512'({1'b1, held}));
        if (m_tvalid && m_tready) begin
          n_checks++;
          assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL extra_beat: observed tag %0h, expected no beat", m_tdata[7:0]);
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_wide($sformatf("beat_%0h", e.tag),
                       512'({m_tdata, m_tstrb, m_tlast, m_tuser}),
                       512'({{32{e.tag}}, e.strb, e.last, TU_HI, e.len}));
          end
        end
        stall_prev = m_tvalid && !m_tready;
        held       = {m_tdata, m_tstrb, m_tlast, m_tuser};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r;
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; s_tstrb = '0; s_tuser = '0;
    m_tready = 1'b1; snaplen = 8'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_tready", 32'(s_tready), 32'd0);
    check_wide("rst_outputs", 512'({m_tvalid, m_tlast, m_tdata, m_tstrb, m_tuser}), 512'd0);
    check("rst_pkt", pkt_count, 32'd0);
    check("rst_trunc", trunc_count, 32'd0);
    rst = 1'b0;
    #1;
    check("tready_after_release", 32'(s_tready), 32'd1);

    // snaplen 0: 5-beat packet of 150 bytes passes unchanged
    snaplen = 8'd0;
    push(8'h11, 1'b0, FULL, 16'd150);
    push(8'h12, 1'b0, FULL, 16'd0);
    push(8'h13, 1'b0, FULL, 16'd0);
    push(8'h14, 1'b0, FULL, 16'd0);
    push(8'h15, 1'b1, 32'h003F_FFFF, 16'd0);
    send_pkt(8'h11, 5, 16'd150, 32'h003F_FFFF);
    drain();
    check("t1_pkt", pkt_count, 32'd1);
    check("t1_trunc", trunc_count, 32'd0);

    // snaplen 2: 6-beat packet of 180 bytes cut to 2 beats; dropped beats accepted while stalled
    snaplen = 8'd2;
    push(8'h21, 1'b0, FULL, 16'd64);
    push(8'h22, 1'b1, FULL, 16'd0);
    send_beat(8'h21, 1'b0, FULL, 16'd180, r);
    send_beat(8'h22, 1'b0, 32'h0F0F_0F0F, 16'd0, r);
    m_tready = 1'b0;
    send_beat(8'h23, 1'b0, FULL, 16'd0, r);
    check("t2_drop_rdy3", 32'(r), 32'd1);
    send_beat(8'h24, 1'b0, FULL, 16'd0, r);
    check("t2_drop_rdy4", 32'(r), 32'd1);
    send_beat(8'h25, 1'b0, FULL, 16'd0, r);
    check("t2_drop_rdy5", 32'(r), 32'd1);
    send_beat(8'h26, 1'b1, 32'h000F_FFFF, 16'd0, r);
    check("t2_drop_rdy6", 32'(r), 32'd1);
    check("t2_trunc", trunc_count, 32'd1);
    m_tready = 1'b1;
    drain();
    check("t2_pkt", pkt_count, 32'd2);

    // Exactly snap beats: not truncated
    snaplen = 8'd3;
    push(8'h31, 1'b0, FULL, 16'd90);
    push(8'h32, 1'b0, FULL, 16'd0);
    push(8'h33, 1'b1, 32'h03FF_FFFF, 16'd0);
    send_pkt(8'h31, 3, 16'd90, 32'h03FF_FFFF);
    drain();
    check("t3a_pkt", pkt_count, 32'd3);
    check("t3a_trunc", trunc_count, 32'd1);

    // Same shape with snaplen 1: single beat out, length 32
    snaplen = 8'd1;
    push(8'h34, 1'b1, FULL, 16'd32);
    send_pkt(8'h34, 3, 16'd90, 32'h03FF_FFFF);
    drain();
    check("t3b_pkt", pkt_count, 32'd4);
    check("t3b_trunc", trunc_count, 32'd2);

    // m_tready toggling over back-to-back packets
    tog_mode = 1'b1;
    snaplen  = 8'd0;
    push(8'h41, 1'b0, FULL, 16'd70);
    push(8'h42, 1'b0, FULL, 16'd0);
    push(8'h43, 1'b1, 32'h0000_003F, 16'd0);
    send_pkt(8'h41, 3, 16'd70, 32'h0000_003F);
    snaplen = 8'd2;
    push(8'h44, 1'b0, FULL, 16'd64);
    push(8'h45, 1'b1, FULL, 16'd0);
    send_pkt(8'h44, 4, 16'd100, 32'h0000_000F);
    snaplen = 8'd0;
    push(8'h48, 1'b0, FULL, 16'd40);
    push(8'h49, 1'b1, 32'h0000_00FF, 16'd0);
    send_pkt(8'h48, 2, 16'd40, 32'h0000_00FF);
    drain();
    tog_mode = 1'b0;
    m_tready = 1'b1;
    check("t4_pkt", pkt_count, 32'd7);
    check("t4_trunc", trunc_count, 32'd3);

    // snaplen changed mid-packet is ignored; the next packet picks up the new value
    snaplen = 8'd2;
    push(8'h51, 1'b0, FULL, 16'd64);
    push(8'h52, 1'b1, FULL, 16'd0);
    send_beat(8'h51, 1'b0, FULL, 16'd180, r);
    snaplen = 8'd8;
    for (int i = 2; i <= 6; i++)
      send_beat(8'h50 + 8'(i), (i == 6), (i == 6) ? 32'h000F_FFFF : FULL, 16'd0, r);
    check("t5a_trunc", trunc_count, 32'd4);
    push(8'h60, 1'b0, FULL, 16'd256);
    for (int i = 1; i < 8; i++) push(8'h60 + 8'(i), (i == 7), FULL, 16'd0);
    send_pkt(8'h60, 10, 16'd320, FULL);
    drain();
    check("t5_pkt", pkt_count, 32'd9);
    check("t5_trunc", trunc_count, 32'd5);

    // Single-beat packet with snaplen 1 is not a truncation
    snaplen = 8'd1;
    push(8'h70, 1'b1, 32'h000F_FFFF, 16'd20);
    send_beat(8'h70, 1'b1, 32'h000F_FFFF, 16'd20, r);
    drain();
    check("t6_pkt", pkt_count, 32'd10);
    check("t6_trunc", trunc_count, 32'd5);

    // Reset on beat 3 of 6; beats 4-6 form a new packet
    snaplen = 8'd0;
    push(8'h71, 1'b0, FULL, 16'd180);
    push(8'h72, 1'b0, FULL, 16'd0);
    send_beat(8'h71, 1'b0, FULL, 16'd180, r);
    send_beat(8'h72, 1'b0, FULL, 16'd0, r);
    send_beat(8'h73, 1'b0, FULL, 16'd0, r);
    rst = 1'b1;
    #1;
    check("mid_rst_tready", 32'(s_tready), 32'd0);
    check_wide("mid_rst_outputs", 512'({m_tvalid, m_tlast, m_tdata, m_tstrb, m_tuser}), 512'd0);
    check("mid_rst_pkt", pkt_count, 32'd0);
    check("mid_rst_trunc", trunc_count, 32'd0);
    snaplen = 8'd2;
    clk_step();
    rst = 1'b0;
    #1;
    check("mid_rst_release_tready", 32'(s_tready), 32'd1);
    push(8'h74, 1'b0, FULL, 16'd0);
    push(8'h75, 1'b1, FULL, 16'd0);
    send_beat(8'h74, 1'b0, FULL, 16'd0, r);
    send_beat(8'h75, 1'b0, FULL, 16'd0, r);
    send_beat(8'h76, 1'b1, 32'h000F_FFFF, 16'd0, r);
    drain();
    check("t7_pkt", pkt_count, 32'd1);
    check("t7_trunc", trunc_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/capture_truncate.md
CAPTURE_TRUNCATE -- requirements
Module: capture_truncate

Interface
REQ-001 SHALL have parameter C_M_AXIS_DATA_WIDTH, default 256: data width, master side.
REQ-002 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256: data width, slave side; must equal master width.
REQ-003 SHALL have parameter C_M_AXIS_TUSER_WIDTH / C_S_AXIS_TUSER_WIDTH, default 128 each: sideband width; tuser[15:0] is packet length in bytes.
REQ-004 SHALL have port axi_aclk, input, 1: the single clock.
REQ-005 SHALL have port axi_areset, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have slave stream ports: s_axis_tdata, tstrb (W/8), tuser, tvalid and tlast as inputs; s_axis_tready as output.
REQ-007 SHALL have master stream ports: m_axis_tdata, tstrb, tuser, tvalid and tlast as outputs; m_axis_tready as input.
REQ-008 SHALL have port snaplen_words, input, 8: maximum beats forwarded per packet; 0 = no truncation.
REQ-009 SHALL have port pkt_count, output, 32: packets whose tlast was forwarded.
REQ-010 SHALL have port trunc_count, output, 32: packets that were truncated.

Function
REQ-011 SHALL sit downstream of the capture merge stage and forward each packet unchanged, or truncate it to at most snaplen_words beats.
REQ-012 SHALL register all master outputs: one output register stage, so data latency is exactly 1 cycle.
REQ-013 SHALL drive s_axis_tready = !m_axis_tvalid || m_axis_tready in states IDLE and PASS.
REQ-014 SHALL drive s_axis_tready = 1 in state DROP; dropped beats are never presented on the master side.
REQ-015 SHALL hold the master output stable while m_axis_tvalid=1 and m_axis_tready=0 (AXI-Stream hold rule).
REQ-016 SHALL latch snaplen_words only on an accepted first beat, into snap_q; mid-packet changes have no effect.
REQ-017 SHALL use a beat counter of 8 bits: cleared on an accepted first beat, incremented per accepted beat, saturating at 255.
REQ-018 SHALL implement states IDLE, PASS and DROP with these transitions:
- IDLE -> PASS: first beat accepted, tlast=0, and (snap=0 or snap>1).
- IDLE -> DROP: first beat accepted, tlast=0, snap=1.
- PASS -> IDLE: tlast beat accepted.
- PASS -> DROP: accepted beat is beat number snap and tlast=0.
- DROP -> IDLE: tlast beat accepted.
- IDLE with tlast=1 on the first beat stays IDLE.
REQ-019 SHALL, on the beat that triggers a transition into DROP, force m_axis_tlast=1 and m_axis_tstrb all-ones on that forwarded beat.
REQ-020 SHALL compute truncated length as snap*32 bytes at 14-bit width.
REQ-021 SHALL, when that length is less than tuser[15:0] on the first beat, rewrite m_axis_tuser[15:0] to that length; all other tuser bits pass unchanged.
REQ-022 SHALL treat a packet of exactly snap beats (tlast on beat snap) as not truncated: no forced tlast, no tuser rewrite, trunc_count unchanged.
REQ-023 SHALL increment pkt_count by 1 when a master beat with m_axis_tlast=1 completes a handshake.
REQ-024 SHALL increment trunc_count by 1 on entry to DROP.
REQ-025 SHALL let both counters wrap modulo 2^32.
REQ-026 SHALL, when a trigger beat for the DROP transition and a stalled master beat coincide, accept the trigger beat only when the output register is free; no beat is lost or duplicated.

Reset
REQ-027 SHALL, on axi_areset=1, asynchronously set state to IDLE and clear m_axis_tvalid, m_axis_tlast, tdata, tstrb, tuser, the beat counter, snap_q, pkt_count and trunc_count to 0.
REQ-028 SHALL drive s_axis_tready=0 while in reset and 1 on the first cycle after release.
REQ-029 SHALL handle reset mid-packet as follows: the partial packet is abandoned, and the next accepted beat is treated as a first beat.

Verification
REQ-030 SHALL cover: snaplen=0, 5-beat packet of length 150 -> 5 beats out unchanged, tuser[15:0]=150, pkt_count=1, trunc_count=0.
REQ-031 SHALL cover: snaplen=2, 6-beat packet of length 180 -> 2 beats out, beat 2 tlast=1 with tstrb=FFFFFFFF, tuser[15:0]=64, s_axis_tready=1 for beats 3-6, trunc_count=1.
REQ-032 SHALL cover: snaplen=3, 3-beat packet of length 90 -> unchanged, trunc_count=0; the same stimulus with snaplen=1 -> 1 beat out with tlast=1, tuser[15:0]=32.
REQ-033 SHALL cover: m_axis_tready toggling 1010... over back-to-back packets -> output identical to the non-stalled case, no beat loss, tvalid/data stable while stalled.
REQ-034 SHALL cover: snaplen changed from 2 to 8 on beat 2 of a 6-beat packet -> packet truncated at 2 beats; the next packet uses 8.
REQ-035 SHALL cover: reset asserted on beat 3 of 6 -> all outputs 0 immediately; beats 4-6 after release are treated as a new packet starting at beat 4.
